sprite_dma_sched: RTL

//  Frame/line scheduler and shared-memory arbiter for NSPR font/sprite engines.

---
 rtl/sprite_sched_pkg.sv | 43 ++++
 rtl/sprite_collide.sv | 45 ++++
 rtl/sprite_dma_sched.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sprite_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_sched_pkg
//  Purpose  : Shared types and helpers for the sprite DMA scheduler:
//             scheduler state encoding, slot-counter width and flat-bus
//             address extraction.
//  Revision : 1.0  initial release
// ============================================================================
package sprite_sched_pkg;

    // Scheduler states, explicitly 3 bits wide
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_LINE = 3'd2,
        GRANT     = 3'd3,
        GAP       = 3'd4
    } sched_state_t;

    // Default engine count and the slot-counter width that goes with it
    localparam int NSPR_DFLT = 4;
    localparam int SLOTW     = (NSPR_DFLT > 1) ? $clog2(NSPR_DFLT) : 1;

    // Widest flat bus handled by slice_addr: 16 engines x 32-bit addresses
    localparam int c_ADDR_MAX_W = 32;
    localparam int c_VEC_W      = 16 * c_ADDR_MAX_W;

    // Slot-counter width for an arbitrary engine count (never below 1)
    function automatic int slot_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Field k of a flat bus of w-bit fields; caller narrows to w bits
    function automatic logic [c_ADDR_MAX_W-1:0] slice_addr(
        input logic [c_VEC_W-1:0] vec,
        input int                 k,
        input int                 w
    );
        return c_ADDR_MAX_W'(vec >> (k * w));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_collide.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_collide
//  Purpose  : Sticky per-engine collision flags. A flag is set when its
//             engine draws a pixel in the same cycle as any other engine.
//             Present only when SPRITE_COLLIDE_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`ifdef SPRITE_COLLIDE_EN
module sprite_collide #(
    parameter int NSPR = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clr,
    input  logic [NSPR-1:0] i_pix,
    output logic [NSPR-1:0] o_flags
);
    logic [NSPR-1:0] r_flags_q;
    logic [NSPR-1:0] w_flags_d;
    logic            w_multi;

    // Two or more pixels at once: clearing the lowest set bit leaves something
    always_comb begin
        w_multi   = ((i_pix & (i_pix - NSPR'(1))) != '0);
        w_flags_d = r_flags_q | (w_multi ? i_pix : '0);
        if (i_clr) begin
            w_flags_d = '0;
        end
    end

    // Flag register, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags_q <= '0;
        end else begin
            r_flags_q <= w_flags_d;
        end
    end

    assign o_flags = r_flags_q;

endmodule
`endif
`default_nettype wire

// File: rtl/sprite_dma_sched.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_dma_sched
//  Purpose  : Frame/line scheduler and sprite-ROM arbiter for NSPR engines.
//             Starts enabled engines at frame start, then opens one DMA
//             window per scanline, granting the ROM slot by slot
//             (grant cycle followed by a gap cycle for each engine).
//  Config   : SPRITE_COLLIDE_EN adds spr_pix/collide and sticky collision
//             flags.
//  Revision : 1.0  initial release
// ============================================================================
module sprite_dma_sched
    import sprite_sched_pkg::*;
#(
    parameter int NSPR  = 4,
    parameter int ADDRW = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  line_start,
    input  logic [NSPR-1:0]       spr_en,
    input  logic [NSPR-1:0]       spr_done,
    input  logic [NSPR*ADDRW-1:0] spr_pos,
    input  logic [NSPR*ADDRW-1:0] spr_base,
`ifdef SPRITE_COLLIDE_EN
    input  logic [NSPR-1:0]       spr_pix,
    output logic [NSPR-1:0]       collide,
`endif
    output logic [NSPR-1:0]       spr_start,
    output logic [NSPR-1:0]       dma_avail,
    output logic [ADDRW-1:0]      mem_addr,
    output logic                  mem_en,
    output logic                  all_done,
    output logic                  overrun
);
    localparam int c_SLOTW = slot_width(NSPR);

    sched_state_t       r_state_q,    w_state_d;
    logic [c_SLOTW-1:0] r_slot_q,     w_slot_d;
    logic [NSPR-1:0]    r_en_l_q,     w_en_l_d;
    logic [NSPR-1:0]    r_seen_q,     w_seen_d;
    logic [NSPR-1:0]    r_done_q,     w_done_d;
    logic               r_all_done_q, w_all_done_d;
    logic               r_overrun_q,  w_overrun_d;
    logic               w_frame_acc;
    logic [NSPR-1:0]    w_grant;
    logic [ADDRW-1:0]   w_base_sel;
    logic [ADDRW-1:0]   w_pos_sel;

    // Next-state logic: frame/line sequencing, done tracking, error flag
    always_comb begin
        w_state_d    = r_state_q;
        w_slot_d     = r_slot_q;
        w_en_l_d     = r_en_l_q;
        w_seen_d     = r_seen_q | (spr_done & ~r_done_q);
        w_done_d     = spr_done;
        w_all_done_d = r_all_done_q;
        w_overrun_d  = r_overrun_q;
        w_frame_acc  = 1'b0;

        case (r_state_q)
            IDLE: begin
                if (frame_start) begin
                    w_en_l_d     = spr_en;
                    w_seen_d     = '0;
                    w_all_done_d = 1'b0;
                    w_frame_acc  = 1'b1;
                    w_state_d    = START;
                end
            end
            START: begin
                w_state_d = WAIT_LINE;
            end
            WAIT_LINE: begin
                if ((r_seen_q & r_en_l_q) == r_en_l_q) begin
                    w_all_done_d = 1'b1;
                    w_state_d    = IDLE;
                end else if (line_start) begin
                    w_slot_d  = '0;
                    w_state_d = GRANT;
                end
            end
            GRANT: begin
                w_state_d = GAP;
            end
            GAP: begin
                if (r_slot_q == c_SLOTW'(NSPR - 1)) begin
                    w_state_d = WAIT_LINE;
                end else begin
                    w_slot_d  = r_slot_q + c_SLOTW'(1);
                    w_state_d = GRANT;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        // Pulses arriving where they cannot be honoured are dropped and flagged
        if (frame_start && (r_state_q != IDLE)) begin
            w_overrun_d = 1'b1;
        end
        if (line_start && ((r_state_q == GRANT) || (r_state_q == GAP))) begin
            w_overrun_d = 1'b1;
        end
    end

    // Scheduler state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= IDLE;
            r_slot_q     <= '0;
            r_en_l_q     <= '0;
            r_seen_q     <= '0;
            r_done_q     <= '0;
            r_all_done_q <= 1'b0;
            r_overrun_q  <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_slot_q     <= w_slot_d;
            r_en_l_q     <= w_en_l_d;
            r_seen_q     <= w_seen_d;
            r_done_q     <= w_done_d;
            r_all_done_q <= w_all_done_d;
            r_overrun_q  <= w_overrun_d;
        end
    end

    // One-hot grant for the current slot, withheld once the engine is done
    always_comb begin
        w_grant = '0;
        if (r_state_q == GRANT) begin
            w_grant[r_slot_q] = r_en_l_q[r_slot_q] & ~r_seen_q[r_slot_q];
        end
    end

    // Address of the current slot's engine; the sum wraps at ADDRW bits
    assign w_base_sel = ADDRW'(slice_addr(c_VEC_W'(spr_base), int'(r_slot_q), ADDRW));
    assign w_pos_sel  = ADDRW'(slice_addr(c_VEC_W'(spr_pos),  int'(r_slot_q), ADDRW));

    assign dma_avail = w_grant;
    assign mem_en    = |w_grant;
    assign mem_addr  = (r_state_q == GRANT) ? (w_base_sel + w_pos_sel) : '0;
    assign spr_start = (r_state_q == START) ? r_en_l_q : '0;
    assign all_done  = r_all_done_q;
    assign overrun   = r_overrun_q;

`ifdef SPRITE_COLLIDE_EN
    sprite_collide #(
        .NSPR (NSPR)
    ) u_collide (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_frame_acc),
        .i_pix   (spr_pix),
        .o_flags (collide)
    );
`endif

endmodule
`default_nettype wire
